yolo_xfer_sched: RTL and testbench

YOLO_XFER_SCHED -- requirements
Module: yolo_xfer_sched

---
 rtl/yolo_xfer_sched.sv | 173 +++++++++++++++++
 tb/tb_yolo_xfer_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/yolo_xfer_sched.sv
// -----------------------------------------------------------------------------
// yolo_xfer_sched
//
// Splits one configured DDR transfer job into a sequence of bursts and issues
// them one at a time to a DDR port. Each burst is at most BURST_MAX beats of
// 32-bit words. The next burst is only requested after the previous one has
// reported completion.
//
// Optional feature: define XFER_4K_SPLIT_EN to also clip every burst so that
// it never crosses a 4096-byte address boundary.
//
// Parameters
//   ADDR_W     DDR byte-address width (>= 12 when XFER_4K_SPLIT_EN is defined)
//   LEN_W      transfer-length width in 32-bit words (>= 9)
//   BURST_MAX  maximum beats per burst, power of two, 1..256
//
// Ports
//   sys_clk_50m  in   sole clock, rising edge
//   hard_rst     in   asynchronous active-high reset
//   cfg_start    in   one-cycle start pulse, configuration sampled this cycle
//   cfg_len      in   total words to move
//   cfg_type     in   0x0 feature write, 0x10 bias/weight write, 0x20 read
//   cfg_addr     in   DDR start byte address (must be word aligned)
//   req_valid    out  burst request valid
//   req_ready    in   DDR port accepts the request
//   req_write    out  1 = DDR write, 0 = DDR read
//   req_addr     out  burst start byte address
//   req_beats    out  burst length in beats
//   burst_done   in   one-cycle pulse when the outstanding burst completes
//   busy         out  high whenever a job is in progress
//   done         out  one-cycle pulse at successful job end
//   err          out  one-cycle pulse when the configuration is rejected
//   dbg_state    out  current FSM state encoding
//
// Request handshake: req_valid, req_write, req_addr and req_beats are held
// stable from the first cycle req_valid is high until the cycle in which
// req_valid and req_ready are both high; that cycle transfers the request.
// -----------------------------------------------------------------------------
module yolo_xfer_sched #(
   parameter int ADDR_W    = 32,
   parameter int LEN_W     = 32,
   parameter int BURST_MAX = 16
) (
   input  logic              sys_clk_50m,
   input  logic              hard_rst,
   input  logic              cfg_start,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [31:0]       cfg_type,
   input  logic [ADDR_W-1:0] cfg_addr,
   output logic              req_valid,
   input  logic              req_ready,
   output logic              req_write,
   output logic [ADDR_W-1:0] req_addr,
   output logic [8:0]        req_beats,
   input  logic              burst_done,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_FIN   = 3'd4,
      ST_ERR   = 3'd5
   } state_t;

   localparam logic [31:0] TYPE_FEAT_WR = 32'h0000_0000;
   localparam logic [31:0] TYPE_BW_WR   = 32'h0000_0010;
   localparam logic [31:0] TYPE_RD      = 32'h0000_0020;
   localparam logic [8:0]  BEATS_MAX    = 9'(BURST_MAX);

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [31:0]       type_q, type_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [8:0]        beats_c;
   logic              cfg_bad_c;

   // Size of the burst that would be issued from the current position.
   // Both rem_q and addr_q only change on burst_done, so this is stable
   // for as long as a request is pending.
   always_comb begin
      beats_c = BEATS_MAX;
      if (rem_q < LEN_W'(BURST_MAX)) begin
         beats_c = 9'(rem_q);
      end
`ifdef XFER_4K_SPLIT_EN
      begin
         logic [10:0] room_c;
         // Words left before the next 4 KB boundary: 1..1024.
         room_c = 11'd1024 - {1'b0, addr_q[11:2]};
         if (room_c < {2'b00, beats_c}) begin
            beats_c = room_c[8:0];
         end
      end
`endif
   end

   always_comb begin
      cfg_bad_c = (rem_q == '0) || (addr_q[1:0] != 2'b00) ||
                  !((type_q == TYPE_FEAT_WR) || (type_q == TYPE_BW_WR) ||
                    (type_q == TYPE_RD));
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      type_d  = type_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               rem_d   = cfg_len;
               type_d  = cfg_type;
               addr_d  = cfg_addr;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            state_d = cfg_bad_c ? ST_ERR : ST_ISSUE;
         end
         ST_ISSUE: begin
            if (req_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // cfg_start is deliberately not looked at here, so a start that
            // coincides with burst_done is simply dropped.
            if (burst_done) begin
               rem_d   = rem_q - LEN_W'(beats_c);
               addr_d  = addr_q + ADDR_W'({beats_c, 2'b00});
               state_d = (rem_q == LEN_W'(beats_c)) ? ST_FIN : ST_ISSUE;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_50m or posedge hard_rst) begin
      if (hard_rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         type_q  <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         type_q  <= type_d;
         addr_q  <= addr_d;
      end
   end

   // Outputs decode directly from registers, so they clear with the
   // asynchronous reset without waiting for a clock.
   always_comb begin
      busy      = (state_q != ST_IDLE);
      req_valid = (state_q == ST_ISSUE);
      req_write = busy && (type_q != TYPE_RD);
      req_addr  = addr_q;
      req_beats = beats_c;
      done      = (state_q == ST_FIN);
      err       = (state_q == ST_ERR);
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_yolo_xfer_sched.sv
module tb_yolo_xfer_sched;

   localparam int ADDR_W    = 32;
   localparam int LEN_W     = 32;
   localparam int BURST_MAX = 16;

   logic              sys_clk_50m = 1'b0;
   logic              hard_rst    = 1'b1;
   logic              cfg_start   = 1'b0;
   logic [LEN_W-1:0]  cfg_len     = '0;
   logic [31:0]       cfg_type    = '0;
   logic [ADDR_W-1:0] cfg_addr    = '0;
   logic              req_valid;
   logic              req_ready   = 1'b0;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [8:0]        req_beats;
   logic              burst_done  = 1'b0;
   logic              busy;
   logic              done;
   logic              err;
   logic [2:0]        dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   int hs_cnt  = 0;

   // expected request: {write, addr[31:0], beats[8:0]}
   logic [41:0] exp_q[$];

   yolo_xfer_sched #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_MAX(BURST_MAX)
   ) dut (
      .sys_clk_50m(sys_clk_50m), .hard_rst(hard_rst),
      .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_type(cfg_type),
      .cfg_addr(cfg_addr), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_beats(req_beats),
      .burst_done(burst_done), .busy(busy), .done(done), .err(err),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #10 sys_clk_50m = ~sys_clk_50m;

   always @(posedge sys_clk_50m) begin
      if (!hard_rst && req_valid && req_ready) hs_cnt++;
   end

   task automatic step();
      @(posedge sys_clk_50m);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int push_bursts(input logic [31:0] len, input logic [31:0] typ,
                                      input logic [31:0] addr);
      logic [31:0] rem;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] room;
      int          n;
      rem = len;
      a   = addr;
      n   = 0;
      while (rem != 0) begin
         b = (rem < BURST_MAX) ? rem : BURST_MAX;
`ifdef XFER_4K_SPLIT_EN
         room = (32'd4096 - {20'd0, a[11:0]}) / 4;
         if (room < b) b = room;
`else
         room = 32'd0;
`endif
         exp_q.push_back({(typ != 32'h20), a, b[8:0]});
         rem = rem - b;
         a   = a + (b * 4);
         n++;
      end
      return n;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input logic [31:0] len, input logic [31:0] typ,
                              input logic [31:0] addr);
      cfg_start = 1'b1;
      cfg_len   = len;
      cfg_type  = typ;
      cfg_addr  = addr;
      step();
      cfg_start = 1'b0;
   endtask

   // Returns 1 once req_valid is seen, 0 after the cycle budget runs out.
   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 10; t++) begin
         if (req_valid) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      check("req_valid_seen", 64'(ok), 64'd1);
   endtask

   task automatic run_job(input logic [31:0] len, input logic [31:0] typ,
                          input logic [31:0] addr, input int rdy_dly,
                          input int bd_dly_max, input bit inject);
      logic [41:0] e;
      int          nb;
      int          hs0;
      int          d;
      bit          ok;
      hs0 = hs_cnt;
      nb  = push_bursts(len, typ, addr);
      pulse_start(len, typ, addr);
      check("busy_after_start", 64'(busy), 64'd1);
      for (int b = 0; b < nb; b++) begin
         wait_valid(ok);
         if (!ok) begin
            exp_q.delete();
            return;
         end
         e = exp_q.pop_front();
         check("req_write", 64'(req_write), 64'(e[41]));
         check("req_addr",  64'(req_addr),  64'(e[40:9]));
         check("req_beats", 64'(req_beats), 64'(e[8:0]));
         for (int k = 0; k < rdy_dly; k++) begin
            // a stray burst_done while a request is pending must be ignored
            burst_done = (k == 0);
            step();
            burst_done = 1'b0;
            check("hold_valid", 64'(req_valid), 64'd1);
            check("hold_write", 64'(req_write), 64'(e[41]));
            check("hold_addr",  64'(req_addr),  64'(e[40:9]));
            check("hold_beats", 64'(req_beats), 64'(e[8:0]));
         end
         req_ready = 1'b1;
         step();
         req_ready = 1'b0;
         check("valid_after_hs", 64'(req_valid), 64'd0);
         d = inject ? 2 : $urandom_range(bd_dly_max, 0);
         for (int k = 0; k < d; k++) begin
            if (inject && k == 0) begin
               cfg_start = 1'b1; cfg_len = 32'd3; cfg_type = 32'h10; cfg_addr = 32'h40;
            end
            step();
            cfg_start = 1'b0;
            check("wait_no_valid", 64'(req_valid), 64'd0);
         end
         if (inject) begin
            cfg_start = 1'b1; cfg_len = 32'd7; cfg_type = 32'h0; cfg_addr = 32'h80;
         end
         burst_done = 1'b1;
         step();
         burst_done = 1'b0;
         cfg_start  = 1'b0;
         if (b == nb - 1) begin
            check("done_pulse", 64'(done), 64'd1);
            check("no_valid_at_fin", 64'(req_valid), 64'd0);
         end else begin
            check("next_valid_gap", 64'(req_valid), 64'd1);
         end
      end
      step();
      check("done_cleared", 64'(done), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);
      check("hs_count", 64'(hs_cnt - hs0), 64'(nb));
      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run_err(input logic [31:0] len, input logic [31:0] typ,
                          input logic [31:0] addr);
      int hs0;
      hs0 = hs_cnt;
      pulse_start(len, typ, addr);
      check("err_not_early", 64'(err), 64'd0);
      step();
      check("err_pulse", 64'(err), 64'd1);
      check("err_no_valid", 64'(req_valid), 64'd0);
      step();
      check("err_cleared", 64'(err), 64'd0);
      check("err_busy_idle", 64'(busy), 64'd0);
      check("err_no_hs", 64'(hs_cnt - hs0), 64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit ok;
      #5;
      check("rst_valid", 64'(req_valid), 64'd0);
      check("rst_busy",  64'(busy),      64'd0);
      check("rst_done",  64'(done),      64'd0);
      check("rst_err",   64'(err),       64'd0);
      step();
      step();
      hard_rst = 1'b0;
      step();
      check("idle_state", 64'(dbg_state), 64'd0);

      // three-burst read with ready always granted
      run_job(32'd40, 32'h20, 32'h1000, 0, 0, 1'b0);

      // rejected configurations
      run_err(32'd0, 32'h20, 32'h1000);
      run_err(32'd8, 32'h5,  32'h1000);
      run_err(32'd8, 32'h20, 32'h1002);

      // write held off by req_ready for 5 cycles
      run_job(32'd8, 32'h10, 32'h2000, 5, 2, 1'b0);

      // 4 KB boundary behaviour depends on XFER_4K_SPLIT_EN
      run_job(32'd16, 32'h0, 32'h0FF0, 1, 1, 1'b0);

      // start pulses during WAIT (also coincident with burst_done)
      run_job(32'd40, 32'h0, 32'h3000, 0, 0, 1'b1);

      // reset while a burst is outstanding
      void'(push_bursts(32'd32, 32'h0, 32'h5000));
      pulse_start(32'd32, 32'h0, 32'h5000);
      wait_valid(ok);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      check("rst_test_in_wait", 64'(dbg_state), 64'd3);
      #3;
      hard_rst = 1'b1;
      #1;
      check("midrst_valid", 64'(req_valid), 64'd0);
      check("midrst_write", 64'(req_write), 64'd0);
      check("midrst_addr",  64'(req_addr),  64'd0);
      check("midrst_beats", 64'(req_beats), 64'd0);
      check("midrst_busy",  64'(busy),      64'd0);
      check("midrst_done",  64'(done),      64'd0);
      check("midrst_err",   64'(err),       64'd0);
      burst_done = 1'b1;
      step();
      burst_done = 1'b0;
      step();
      check("midrst_no_done", 64'(done), 64'd0);
      hard_rst = 1'b0;
      exp_q.delete();
      run_job(32'd20, 32'h20, 32'h6000, 0, 1, 1'b0);

      // random jobs
      for (int j = 0; j < 6; j++) begin
         logic [31:0] rl;
         logic [31:0] ra;
         logic [31:0] rt;
         rl = $urandom_range(50, 1);
         ra = {$urandom_range(32'h3FFF, 0), 2'b00};
         case ($urandom_range(2, 0))
            0:       rt = 32'h0;
            1:       rt = 32'h10;
            default: rt = 32'h20;
         endcase
         run_job(rl, rt, ra, $urandom_range(3, 0), 3, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
